regfile_wb_arbiter: RTL

- Shares the single write port of the 4x64 register file between N_REQ writeback requesters, e.g. ALU, load unit and immediate/move path.
- Per-requester valid/ready handshake with round-robin grant.
- One registered output stage drives the register-file write port.
- Exposes a pending-write mask so issue logic can detect read-after-write hazards against the buffered write.

---
 rtl/regfile_wb_arbiter_if.sv | 27 ++
 rtl/regfile_wb_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter_if.sv
// Writeback bus between N_REQ requesters and the register-file write arbiter.
// Requester handshakes and the register-file write port share this one bundle.
interface regfile_wb_arbiter_if #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 2
);
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ-1:0]        req_ready;
  logic [N_REQ*ADDR_W-1:0] req_addr;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic                    wr_hold;
  logic                    rf_write_enable;
  logic [ADDR_W-1:0]       rf_write_addr;
  logic [DATA_W-1:0]       rf_write_data;
  logic [2**ADDR_W-1:0]    pending_mask;

  modport master (
    output req_valid, req_addr, req_data, wr_hold,
    input  req_ready, rf_write_enable, rf_write_addr, rf_write_data, pending_mask
  );

  modport slave (
    input  req_valid, req_addr, req_data, wr_hold,
    output req_ready, rf_write_enable, rf_write_addr, rf_write_data, pending_mask
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single register-file write port among N_REQ
// writeback requesters, with one registered output stage and a pending-write mask.
module regfile_wb_arbiter #(
  parameter int unsigned N_REQ  = 3,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned ADDR_W = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  regfile_wb_arbiter_if.slave  bus
);
  localparam int unsigned PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q,  out_addr_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [PTR_W-1:0]  rr_ptr_q,    rr_ptr_d;

  logic [N_REQ-1:0]  grant;
  logic [PTR_W-1:0]  gnt_idx;
  logic              found;
  logic [PTR_W:0]    scan_sum;
  logic [PTR_W-1:0]  scan_idx;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic              accept_en;
  logic              accept;

  assign accept_en = ~out_valid_q | ~bus.wr_hold;

  // Scan from rr_ptr upward, wrapping modulo N_REQ; first valid wins.
  always_comb begin
    grant    = '0;
    gnt_idx  = '0;
    found    = 1'b0;
    scan_sum = '0;
    scan_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      scan_sum = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(N_REQ)) scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found && bus.req_valid[scan_idx]) begin
        grant[scan_idx] = 1'b1;
        gnt_idx         = scan_idx;
        found           = 1'b1;
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (grant[k]) begin
        sel_addr = bus.req_addr[k*ADDR_W +: ADDR_W];
        sel_data = bus.req_data[k*DATA_W +: DATA_W];
      end
    end
  end

  assign bus.req_ready = (rst_n && accept_en) ? grant : '0;
  assign accept        = |bus.req_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_addr_d  = sel_addr;
      out_data_d  = sel_data;
      rr_ptr_d    = (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + 1'b1;
    end else if (accept_en) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
      rr_ptr_q    <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Gated by rst_n so a buffered write is dropped rather than committed during reset.
  assign bus.rf_write_enable = out_valid_q & ~bus.wr_hold & rst_n;
  assign bus.rf_write_addr   = out_addr_q;
  assign bus.rf_write_data   = out_data_q;

  always_comb begin
    bus.pending_mask = '0;
    for (int unsigned k = 0; k < 2**ADDR_W; k++) begin
      bus.pending_mask[k] = out_valid_q && (out_addr_q == ADDR_W'(k));
    end
  end
endmodule
